// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage of the 16-bit pipeline.
// Owns the fetch PC and keeps at most one request outstanding to
// instruction memory. It drives the pc/instruction pair into the IF/ID
// register. A one-entry buffer catches a word that returns while IF/ID
// is stalled. A taken branch squashes the stage to NOP and redirects
// fetch.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   stall          IF/ID stalled: hold pc/instruction
//   branch_taken   redirect fetch to branch_target, squash stage
//   branch_target  new fetch PC (word address)
//   imem_req       request valid (decoded from registered state only)
//   imem_addr      request word address
//   imem_ready     memory returns imem_rdata this cycle, completes request
//   imem_rdata     instruction word, valid with imem_ready
//   pc             PC of the word on instruction
//   instruction    instruction word, NOP for bubbles and flushes
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_RST    | first cycle after reset release, no request
// S_FETCH  | request outstanding at fetch_pc
// S_FULL   | buffer holds a word during stall, request suppressed
// S_DISCARD| redirected while a request was outstanding; the old request
//          | is completed and its data dropped

module if_fetch #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [15:0] NOP      = 16'h0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        branch_taken,
   input  logic [15:0] branch_target,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic        imem_ready,
   input  logic [15:0] imem_rdata,
   output logic [15:0] pc,
   output logic [15:0] instruction
);

   typedef enum logic [1:0] {
      S_RST     = 2'd0,
      S_FETCH   = 2'd1,
      S_FULL    = 2'd2,
      S_DISCARD = 2'd3
   } state_t;

   state_t      state, state_d;
   logic [15:0] fetch_pc, fetch_pc_d;
   logic [15:0] req_addr, req_addr_d;
   logic        buf_valid, buf_valid_d;
   logic [15:0] buf_pc, buf_pc_d;
   logic [15:0] buf_instr, buf_instr_d;
   logic [15:0] pc_d, instr_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_RST;
         fetch_pc    <= RESET_PC;
         req_addr    <= RESET_PC;
         buf_valid   <= 1'b0;
         buf_pc      <= RESET_PC;
         buf_instr   <= NOP;
         pc          <= RESET_PC;
         instruction <= NOP;
      end else begin
         state       <= state_d;
         fetch_pc    <= fetch_pc_d;
         req_addr    <= req_addr_d;
         buf_valid   <= buf_valid_d;
         buf_pc      <= buf_pc_d;
         buf_instr   <= buf_instr_d;
         pc          <= pc_d;
         instruction <= instr_d;
      end
   end

   always_comb begin
      state_d     = state;
      fetch_pc_d  = fetch_pc;
      buf_valid_d = buf_valid;
      buf_pc_d    = buf_pc;
      buf_instr_d = buf_instr;
      pc_d        = pc;
      instr_d     = instruction;

      if (branch_taken) begin
         instr_d     = NOP;
         fetch_pc_d  = branch_target;
         buf_valid_d = 1'b0;
         // An unfinished request must still be completed on the old address.
         if ((state == S_FETCH || state == S_DISCARD) && !imem_ready)
            state_d = S_DISCARD;
         else
            state_d = S_FETCH;
      end else if (stall) begin
         case (state)
            S_RST:   state_d = S_FETCH;
            S_FETCH: begin
               if (imem_ready) begin
                  buf_valid_d = 1'b1;
                  buf_pc_d    = fetch_pc;
                  buf_instr_d = imem_rdata;
                  fetch_pc_d  = fetch_pc + 16'd1;
                  state_d     = S_FULL;
               end
            end
            S_DISCARD: begin
               if (imem_ready)
                  state_d = S_FETCH;
            end
            default: ;
         endcase
      end else if (buf_valid) begin
         pc_d        = buf_pc;
         instr_d     = buf_instr;
         buf_valid_d = 1'b0;
         state_d     = S_FETCH;
      end else begin
         instr_d = NOP;
         case (state)
            S_RST:   state_d = S_FETCH;
            S_FETCH: begin
               if (imem_ready) begin
                  pc_d       = fetch_pc;
                  instr_d    = imem_rdata;
                  fetch_pc_d = fetch_pc + 16'd1;
               end
            end
            S_DISCARD: begin
               if (imem_ready)
                  state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
         endcase
      end

      // While discarding, the address presented stays on the stale request.
      req_addr_d = (state_d == S_DISCARD) ? req_addr : fetch_pc_d;
   end

   assign imem_req  = (state == S_FETCH) || (state == S_DISCARD);
   assign imem_addr = req_addr;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: a directed vector table, hand-written corner sequences
// and a randomized run, all against a queue-based fetch model.
module tb_if_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        branch_taken;
   logic [15:0] branch_target;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_ready;
   logic [15:0] imem_rdata;
   logic [15:0] pc;
   logic [15:0] instruction;

   localparam logic [15:0] NOPW = 16'h0000;

   if_fetch dut (
      .clk          (clk),
      .reset        (reset),
      .stall        (stall),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ready   (imem_ready),
      .imem_rdata   (imem_rdata),
      .pc           (pc),
      .instruction  (instruction)
   );

   always #5 clk = ~clk;

   // Memory image: each word is its own address xor AAAA.
   assign imem_rdata = imem_addr ^ 16'hAAAA;

   int nvec = 0;
   int nerr = 0;

   // Reference model: fetch pointer, queue of fetched-but-undelivered words,
   // and a flag for a request whose data is to be thrown away.
   bit          m_fresh;
   bit          m_disc;
   logic [15:0] m_old;
   logic [15:0] m_fetch;
   logic [15:0] m_pc;
   logic [15:0] m_instr;
   logic [15:0] m_qpc[$];
   logic [15:0] m_qin[$];

   typedef struct {
      logic        s;
      logic        b;
      logic [15:0] t;
      logic        r;
      logic [15:0] epc;
      logic [15:0] ein;
   } vec_t;

   vec_t tbl[11];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_fresh = 1'b1;
      m_disc  = 1'b0;
      m_old   = 16'h0000;
      m_fetch = 16'h0000;
      m_pc    = 16'h0000;
      m_instr = NOPW;
      m_qpc.delete();
      m_qin.delete();
   endtask

   // Entered just after a rising edge; leaves 1 time unit after the next one.
   task automatic cycle(input logic s, input logic b, input logic [15:0] t, input logic r);
      logic        mreq;
      logic [15:0] maddr;
      logic [15:0] mdata;
      logic        done;
      stall = s;
      branch_taken = b;
      branch_target = t;
      imem_ready = r;
      @(negedge clk);
      mreq  = !m_fresh && (m_disc || m_qpc.size() == 0);
      maddr = m_disc ? m_old : m_fetch;
      mdata = maddr ^ 16'hAAAA;
      done  = mreq && r;
      chk("imem_req", {15'b0, imem_req}, {15'b0, mreq});
      if (mreq)
         chk("imem_addr", imem_addr, maddr);
      if (b) begin
         m_instr = NOPW;
         m_qpc.delete();
         m_qin.delete();
         m_disc  = mreq && !r;
         m_old   = maddr;
         m_fetch = t;
      end else if (s) begin
         if (done) begin
            if (m_disc) m_disc = 1'b0;
            else begin
               m_qpc.push_back(maddr);
               m_qin.push_back(mdata);
               m_fetch = m_fetch + 16'd1;
            end
         end
      end else if (m_qpc.size() != 0) begin
         m_pc    = m_qpc.pop_front();
         m_instr = m_qin.pop_front();
      end else if (done && !m_disc) begin
         m_pc    = maddr;
         m_instr = mdata;
         m_fetch = m_fetch + 16'd1;
      end else begin
         m_instr = NOPW;
         if (done) m_disc = 1'b0;
      end
      m_fresh = 1'b0;
      @(posedge clk);
      #1;
      chk("pc", pc, m_pc);
      chk("instruction", instruction, m_instr);
   endtask

   // Asserts reset between edges and checks outputs before any clock edge.
   task automatic do_reset();
      reset = 1'b1;
      stall = 1'b0;
      branch_taken = 1'b0;
      branch_target = 16'h0000;
      imem_ready = 1'b0;
      #1;
      model_reset();
      chk("rst_pc", pc, 16'h0000);
      chk("rst_instr", instruction, NOPW);
      chk("rst_req", {15'b0, imem_req}, 16'h0000);
      chk("rst_addr", imem_addr, 16'h0000);
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      stall = 1'b0;
      branch_taken = 1'b0;
      branch_target = 16'h0000;
      imem_ready = 1'b0;

      // Zero-wait stream, then a 3-cycle stall while PC 0005 returns.
      tbl[0]  = '{1'b0, 1'b0, 16'h0, 1'b1, 16'h0000, 16'h0000};
      tbl[1]  = '{1'b0, 1'b0, 16'h0, 1'b1, 16'h0000, 16'hAAAA};
      tbl[2]  = '{1'b0, 1'b0, 16'h0, 1'b1, 16'h0001, 16'hAAAB};
      tbl[3]  = '{1'b0, 1'b0, 16'h0, 1'b1, 16'h0002, 16'hAAA8};
      tbl[4]  = '{1'b0, 1'b0, 16'h0, 1'b1, 16'h0003, 16'hAAA9};
      tbl[5]  = '{1'b0, 1'b0, 16'h0, 1'b1, 16'h0004, 16'hAAAE};
      tbl[6]  = '{1'b1, 1'b0, 16'h0, 1'b1, 16'h0004, 16'hAAAE};
      tbl[7]  = '{1'b1, 1'b0, 16'h0, 1'b1, 16'h0004, 16'hAAAE};
      tbl[8]  = '{1'b1, 1'b0, 16'h0, 1'b1, 16'h0004, 16'hAAAE};
      tbl[9]  = '{1'b0, 1'b0, 16'h0, 1'b1, 16'h0005, 16'hAAAF};
      tbl[10] = '{1'b0, 1'b0, 16'h0, 1'b1, 16'h0006, 16'hAAAC};

      do_reset();
      for (int i = 0; i < 11; i++) begin
         cycle(tbl[i].s, tbl[i].b, tbl[i].t, tbl[i].r);
         chk("tbl_pc", pc, tbl[i].epc);
         chk("tbl_instr", instruction, tbl[i].ein);
      end

      // Two wait states per fetch.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 1'b0, 16'h0, 1'b0);
         cycle(1'b0, 1'b0, 16'h0, 1'b0);
         cycle(1'b0, 1'b0, 16'h0, 1'b1);
      end
      chk("wait_pc", pc, 16'h0003);
      chk("wait_instr", instruction, 16'hAAA9);

      // Redirect to 0101 while the request for 0004 is still waiting.
      cycle(1'b0, 1'b0, 16'h0, 1'b0);
      cycle(1'b0, 1'b1, 16'h0101, 1'b0);
      chk("br_instr", instruction, NOPW);
      chk("br_pc_hold", pc, 16'h0003);
      cycle(1'b0, 1'b0, 16'h0, 1'b0);
      cycle(1'b0, 1'b0, 16'h0, 1'b1);
      chk("br_drop_instr", instruction, NOPW);
      chk("br_new_addr", imem_addr, 16'h0101);
      chk("br_new_req", {15'b0, imem_req}, 16'h0001);
      cycle(1'b0, 1'b0, 16'h0, 1'b1);
      chk("br_tgt_pc", pc, 16'h0101);
      chk("br_tgt_instr", instruction, 16'hABAB);

      // Branch together with stall while the buffer is full.
      cycle(1'b1, 1'b0, 16'h0, 1'b1);
      cycle(1'b1, 1'b0, 16'h0, 1'b1);
      chk("full_req", {15'b0, imem_req}, 16'h0000);
      cycle(1'b1, 1'b1, 16'h0200, 1'b1);
      chk("brst_instr", instruction, NOPW);
      chk("brst_pc", pc, 16'h0101);
      cycle(1'b0, 1'b0, 16'h0, 1'b1);
      chk("brst_tgt_pc", pc, 16'h0200);
      chk("brst_tgt_instr", instruction, 16'hA8AA);

      // PC wrap.
      cycle(1'b0, 1'b1, 16'hFFFF, 1'b1);
      cycle(1'b0, 1'b0, 16'h0, 1'b1);
      chk("wrap_pc_ffff", pc, 16'hFFFF);
      chk("wrap_instr_ffff", instruction, 16'h5555);
      cycle(1'b0, 1'b0, 16'h0, 1'b1);
      chk("wrap_pc_0000", pc, 16'h0000);
      chk("wrap_instr_0000", instruction, 16'hAAAA);

      // Reset with a request outstanding, then restart.
      cycle(1'b0, 1'b0, 16'h0, 1'b0);
      do_reset();
      cycle(1'b0, 1'b0, 16'h0, 1'b1);
      cycle(1'b0, 1'b0, 16'h0, 1'b1);
      chk("rerun_pc", pc, 16'h0000);
      chk("rerun_instr", instruction, 16'hAAAA);

      // Randomized traffic.
      for (int i = 0; i < 2000; i++) begin
         logic        s, b, r;
         logic [15:0] t;
         if ($urandom_range(0, 399) == 0) do_reset();
         s = ($urandom_range(0, 3) == 0);
         b = ($urandom_range(0, 19) == 0);
         r = ($urandom_range(0, 9) < 6);
         t = 16'($urandom);
         cycle(s, b, t, r);
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the 16-bit pipeline: owns the fetch PC, issues single-outstanding requests to instruction memory, and drives the `pc`/`instruction` pair consumed by the IF/ID pipeline register. Honours hazard-unit stalls through a one-entry holding buffer and squashes to NOP on a taken branch redirect from the decode/execute side.

## Interface
- `RESET_PC`, 16'h0000, fetch address after reset
- `NOP`, 16'h0000, encoding driven on `instruction` for bubbles/flushes
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `stall`  in  1  hold outputs (IF/ID is stalled)
- `branch_taken`  in  1  redirect fetch; squash stage
- `branch_target`  in  16  new fetch PC when `branch_taken`
- `imem_req`  out  1  memory request valid
- `imem_addr`  out  16  request word address (= fetch PC)
- `imem_ready`  in  1  memory returns `imem_rdata` this cycle; completes request
- `imem_rdata`  in  16  instruction word, valid when `imem_ready`
- `pc`  out  16  registered PC of `instruction`, to IF/ID
- `instruction`  out  16  registered instruction word, to IF/ID

## Operation
- Word addressing: fetch PC increments by 1 per accepted instruction, 16-bit wrap (16'hFFFF -> 16'h0000).
- Internal: `fetch_pc`, 1-entry buffer (`buf_valid`, `buf_pc`, `buf_instr`), FSM.
- FSM states:
  - RST: first cycle after reset release; `imem_req`=0; -> FETCH.
  - FETCH: `imem_req`=1, `imem_addr`=`fetch_pc`; address held stable until `imem_ready`.
  - FULL: buffer holds a word during stall; `imem_req`=0; -> FETCH when `stall`=0.
  - DISCARD: redirect arrived while request outstanding; `imem_req`=1 on old address until `imem_ready`; returned data dropped; then -> FETCH at new `fetch_pc`.
- Per-cycle priority, highest first:
  - `branch_taken`: `instruction`<=NOP, `pc` holds; `fetch_pc`<=`branch_target`; buffer cleared. From FETCH: -> DISCARD if `imem_ready`=0, else data dropped and -> FETCH. From FULL/RST: -> FETCH. In DISCARD: update target, stay until ready. Overrides `stall`.
  - `stall`: `pc`/`instruction` hold. FETCH with `imem_ready`: word to buffer, `fetch_pc`+1, -> FULL.
  - Normal: if `buf_valid`, outputs<=buffer, buffer cleared, -> FETCH; elif FETCH with `imem_ready`, outputs<=(`fetch_pc`, `imem_rdata`), `fetch_pc`+1; else `instruction`<=NOP, `pc` holds (bubble).
- Never more than one request outstanding; buffer never overflows (request suppressed when full).

## Timing
- Reset (async, immediate): `pc`=`RESET_PC`, `instruction`=NOP, `imem_req`=0, `imem_addr`=`RESET_PC`, `fetch_pc`=`RESET_PC`, buffer empty, state RST.
- Reset mid-request: request abandoned; memory must tolerate `imem_req` dropping before ready.
- `imem_req`, `imem_addr` decoded from registered state only (no input-to-output combinational path).
- Latency: `imem_ready` at edge N -> `pc`/`instruction` valid after edge N (1 cycle).
- Zero-wait memory (`imem_ready` tied 1): one instruction per cycle; first real instruction on outputs 2 edges after reset release.
- Redirect: bubble on outputs after the branch edge; target word appears ≥1 cycle after its `imem_ready`.
- Stall release with buffer full: buffered word presented on next edge; new request issued same cycle.

## Test plan
- Reset then zero-wait memory returning `imem_rdata`=addr^16'hAAAA -> outputs (0000,AAAA),(0001,AAAB),(0002,AAA8) on consecutive cycles after initial NOP.
- 2-cycle-wait memory -> NOP bubble between instructions, `imem_addr` stable while `imem_req`=1 and `imem_ready`=0.
- `stall` held 3 cycles while fetch of PC 0005 completes -> outputs frozen, `imem_req`=0 during FULL, (0005,data) on first cycle after release, no word lost or duplicated.
- `branch_taken`, target 16'h0101, during outstanding wait-state request -> DISCARD, stale data dropped, next request `imem_addr`=0101, output (0101,instr) with NOP bubbles before.
- `branch_taken` and `stall` same cycle with buffer full -> buffer cleared, `instruction`=NOP, fetch resumes at target.
- PC wrap: `branch_target`=16'hFFFF, zero-wait -> (FFFF,x) then (0000,y); async `reset` asserted mid-stream -> all outputs reset immediately without waiting for `clk`.
